// File: rtl/iq_arb_mux_rr_select.sv
`default_nettype none
// ============================================================================
//  Module      : iq_rr_select
//  Description : Combinational rotate-priority encoder. Returns the first set
//                bit of the request vector, searching upward from rr_ptr and
//                wrapping past PORTS-1 back to 0.
//  Ports       : req    [PORTS-1:0] - request vector
//                rr_ptr [SEL_W-1:0] - index searched first
//                found              - at least one request is set
//                sel    [SEL_W-1:0] - index of the selected request
//  Revision    : 1.0 - initial release
// ============================================================================
module iq_rr_select #(
    parameter int PORTS = 4,
    parameter int SEL_W = $clog2(PORTS)
) (
    input  logic [PORTS-1:0] req,
    input  logic [SEL_W-1:0] rr_ptr,
    output logic             found,
    output logic [SEL_W-1:0] sel
);

    int               w_idx;
    logic [SEL_W-1:0] w_idx_sel;

    // Walk the offsets from farthest to nearest so that the nearest request
    // (lowest offset from rr_ptr) is the last one written and therefore wins.
    always_comb begin
        found     = 1'b0;
        sel       = '0;
        w_idx     = 0;
        w_idx_sel = '0;
        for (int i = PORTS - 1; i >= 0; i--) begin
            w_idx = int'(rr_ptr) + i;
            if (w_idx >= PORTS) begin
                w_idx = w_idx - PORTS;
            end
            w_idx_sel = SEL_W'(w_idx);
            if (req[w_idx_sel]) begin
                found = 1'b1;
                sel   = w_idx_sel;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/iq_arb_mux.sv
`default_nettype none
// ============================================================================
//  Module      : iq_arb_mux
//  Description : Round-robin arbitrated multiplexer sharing one downstream I/Q
//                AXI-stream path between PORTS sources. A grant lasts up to
//                BURST_LEN transfers or until the granted source drops
//                tvalid. One registered output stage, tagged with source id.
//  Ports       : clk, rst                     - clock, sync active-high reset
//                input_i_tdata/input_q_tdata  - packed per-port I/Q samples
//                input_tvalid/input_tready    - per-port handshake
//                output_i_tdata/output_q_tdata- muxed I/Q samples
//                output_tvalid/output_tready  - downstream handshake
//                output_tid                   - source index of output sample
//  Revision    : 1.0 - initial release
// ============================================================================
module iq_arb_mux #(
    parameter int PORTS     = 4,
    parameter int WIDTH     = 16,
    parameter int BURST_LEN = 16,
    parameter int SEL_W     = $clog2(PORTS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PORTS*WIDTH-1:0] input_i_tdata,
    input  logic [PORTS*WIDTH-1:0] input_q_tdata,
    input  logic [PORTS-1:0]       input_tvalid,
    output logic [PORTS-1:0]       input_tready,
    output logic [WIDTH-1:0]       output_i_tdata,
    output logic [WIDTH-1:0]       output_q_tdata,
    output logic                   output_tvalid,
    input  logic                   output_tready,
    output logic [SEL_W-1:0]       output_tid
);

    localparam int               c_cnt_w     = $clog2(BURST_LEN + 1);
    localparam logic [0:0]       c_idle      = 1'b0;
    localparam logic [0:0]       c_granted   = 1'b1;
    localparam logic [c_cnt_w-1:0] c_last_beat = c_cnt_w'(BURST_LEN - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
    localparam logic [SEL_W-1:0] c_last_port = SEL_W'(PORTS - 1);
    localparam logic [SEL_W-1:0] c_sel_one   = SEL_W'(1);

    logic [0:0]         r_state;
    logic [SEL_W-1:0]   r_grant;
    logic [SEL_W-1:0]   r_rr_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic [WIDTH-1:0]   r_out_i;
    logic [WIDTH-1:0]   r_out_q;
    logic [SEL_W-1:0]   r_out_tid;
    logic               r_out_valid;

    logic [0:0]         w_next_state;
    logic               w_found;
    logic [SEL_W-1:0]   w_sel;
    logic               w_grant_valid;
    logic               w_grant_ready;
    logic               w_xfer;
    logic               w_release;
    logic [PORTS-1:0]   w_ready;
    logic [WIDTH-1:0]   w_mux_i;
    logic [WIDTH-1:0]   w_mux_q;

    iq_rr_select #(
        .PORTS (PORTS),
        .SEL_W (SEL_W)
    ) u_rr_select (
        .req    (input_tvalid),
        .rr_ptr (r_rr_ptr),
        .found  (w_found),
        .sel    (w_sel)
    );

    assign w_mux_i = input_i_tdata[int'(r_grant)*WIDTH +: WIDTH];
    assign w_mux_q = input_q_tdata[int'(r_grant)*WIDTH +: WIDTH];

    always_comb begin
        w_grant_valid = input_tvalid[r_grant];
        // The output register can accept a new sample when it is empty or
        // being drained this cycle; this is the only comb path from outputs.
        w_grant_ready = output_tready | ~r_out_valid;
        w_xfer        = (r_state == c_granted) & w_grant_valid & w_grant_ready;
        w_release     = (r_state == c_granted) &
                        (~w_grant_valid | (w_xfer & (r_count == c_last_beat)));
        w_ready       = '0;
        if (r_state == c_granted) begin
            w_ready[r_grant] = w_grant_ready;
        end
        w_next_state  = r_state;
        case (r_state)
            c_idle:    if (w_found)   w_next_state = c_granted;
            c_granted: if (w_release) w_next_state = c_idle;
            default:   w_next_state = c_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_idle;
            r_grant     <= '0;
            r_rr_ptr    <= '0;
            r_count     <= '0;
            r_out_i     <= '0;
            r_out_q     <= '0;
            r_out_tid   <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state <= w_next_state;

            if ((r_state == c_idle) && w_found) begin
                r_grant <= w_sel;
                r_count <= '0;
            end else if (w_xfer) begin
                // Wrap on the last beat so the counter stays below BURST_LEN.
                r_count <= (r_count == c_last_beat) ? '0 : r_count + c_cnt_one;
            end

            if (w_release) begin
                r_rr_ptr <= (r_grant == c_last_port) ? '0 : r_grant + c_sel_one;
            end

            if (w_xfer) begin
                r_out_i     <= w_mux_i;
                r_out_q     <= w_mux_q;
                r_out_tid   <= r_grant;
                r_out_valid <= 1'b1;
            end else if (output_tready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign input_tready   = w_ready;
    assign output_i_tdata = r_out_i;
    assign output_q_tdata = r_out_q;
    assign output_tid     = r_out_tid;
    assign output_tvalid  = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_iq_arb_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_iq_arb_mux
//  Description : Directed self-checking bench for iq_arb_mux (PORTS=4,
//                WIDTH=16, BURST_LEN=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_iq_arb_mux;

    localparam int PORTS     = 4;
    localparam int WIDTH     = 16;
    localparam int BURST_LEN = 4;
    localparam int SEL_W     = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [PORTS*WIDTH-1:0] input_i_tdata;
    logic [PORTS*WIDTH-1:0] input_q_tdata;
    logic [PORTS-1:0]       input_tvalid;
    logic [PORTS-1:0]       input_tready;
    logic [WIDTH-1:0]       output_i_tdata;
    logic [WIDTH-1:0]       output_q_tdata;
    logic                   output_tvalid;
    logic                   output_tready;
    logic [SEL_W-1:0]       output_tid;

    int errors = 0;
    int checks = 0;

    iq_arb_mux #(
        .PORTS     (PORTS),
        .WIDTH     (WIDTH),
        .BURST_LEN (BURST_LEN),
        .SEL_W     (SEL_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .input_i_tdata  (input_i_tdata),
        .input_q_tdata  (input_q_tdata),
        .input_tvalid   (input_tvalid),
        .input_tready   (input_tready),
        .output_i_tdata (output_i_tdata),
        .output_q_tdata (output_q_tdata),
        .output_tvalid  (output_tvalid),
        .output_tready  (output_tready),
        .output_tid     (output_tid)
    );

    always #5 clk = ~clk;

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_port(input int p, input logic [15:0] i_val, input logic [15:0] q_val);
        input_i_tdata[p*WIDTH +: WIDTH] = i_val;
        input_q_tdata[p*WIDTH +: WIDTH] = q_val;
    endtask

    initial begin
        rst           = 1'b1;
        input_i_tdata = '0;
        input_q_tdata = '0;
        input_tvalid  = '0;
        output_tready = 1'b1;
        go();
        go();
        rst = 1'b0;
        look();
        chk("reset_tvalid", 32'(output_tvalid), 0);
        chk("reset_i", 32'(output_i_tdata), 0);
        chk("reset_q", 32'(output_q_tdata), 0);
        chk("reset_tid", 32'(output_tid), 0);
        chk("reset_ready", 32'(input_tready), 0);

        // Single source on port 2.
        set_port(2, 16'h1234, 16'hABCD);
        input_tvalid = 4'b0100;
        look();
        chk("single_idle_ready", 32'(input_tready), 0);
        go();
        look();
        chk("single_ready", 32'(input_tready), 32'h4);
        go();
        input_tvalid = 4'b0000;
        look();
        chk("single_tvalid", 32'(output_tvalid), 1);
        chk("single_i", 32'(output_i_tdata), 32'h1234);
        chk("single_q", 32'(output_q_tdata), 32'hABCD);
        chk("single_tid", 32'(output_tid), 2);
        go();
        look();
        chk("single_drain_tvalid", 32'(output_tvalid), 0);
        chk("single_release_ready", 32'(input_tready), 0);

        // Wrap: rr_ptr is 3, ports 0 and 3 valid -> 3 first, then 0.
        set_port(3, 16'h3330, 16'h3331);
        set_port(0, 16'h0A00, 16'h0B00);
        input_tvalid = 4'b1001;
        look();
        chk("wrap_idle_ready", 32'(input_tready), 0);
        go();
        look();
        chk("wrap_grant3", 32'(input_tready), 32'h8);
        go();
        input_tvalid = 4'b0001;
        look();
        chk("wrap_tid3", 32'(output_tid), 3);
        chk("wrap_i3", 32'(output_i_tdata), 32'h3330);
        go();
        look();
        chk("wrap_bubble", 32'(input_tready), 0);
        go();
        look();
        chk("wrap_grant0", 32'(input_tready), 32'h1);

        // Back-pressure mid-burst on port 0, three stalled cycles.
        go();
        set_port(0, 16'h0A01, 16'h0B01);
        output_tready = 1'b0;
        look();
        chk("bp_tvalid_0", 32'(output_tvalid), 1);
        chk("bp_i_0", 32'(output_i_tdata), 32'h0A00);
        chk("bp_ready_0", 32'(input_tready), 0);
        go();
        look();
        chk("bp_tvalid_1", 32'(output_tvalid), 1);
        chk("bp_i_1", 32'(output_i_tdata), 32'h0A00);
        chk("bp_ready_1", 32'(input_tready), 0);
        go();
        look();
        chk("bp_tvalid_2", 32'(output_tvalid), 1);
        chk("bp_q_2", 32'(output_q_tdata), 32'h0B00);
        chk("bp_ready_2", 32'(input_tready), 0);
        output_tready = 1'b1;
        look();
        chk("bp_resume_ready", 32'(input_tready), 32'h1);
        go();
        set_port(0, 16'h0A02, 16'h0B02);
        look();
        chk("bp_i_s2", 32'(output_i_tdata), 32'h0A01);
        go();
        set_port(0, 16'h0A03, 16'h0B03);
        look();
        chk("bp_i_s3", 32'(output_i_tdata), 32'h0A02);
        go();
        look();
        chk("bp_i_s4", 32'(output_i_tdata), 32'h0A03);
        chk("bp_tvalid_s4", 32'(output_tvalid), 1);
        chk("bp_burst_end", 32'(input_tready), 0);

        // Early release: port 1 sends two samples, port 3 waits.
        set_port(1, 16'h1100, 16'h1200);
        input_tvalid = 4'b1010;
        go();
        look();
        chk("early_grant1", 32'(input_tready), 32'h2);
        go();
        set_port(1, 16'h1101, 16'h1201);
        look();
        chk("early_i0", 32'(output_i_tdata), 32'h1100);
        chk("early_tid0", 32'(output_tid), 1);
        go();
        input_tvalid = 4'b1000;
        look();
        chk("early_i1", 32'(output_i_tdata), 32'h1101);
        go();
        look();
        chk("early_idle_tvalid", 32'(output_tvalid), 0);
        chk("early_idle_ready", 32'(input_tready), 0);
        go();
        look();
        chk("early_grant3", 32'(input_tready), 32'h8);
        input_tvalid = 4'b0000;
        go();
        look();
        chk("early_drop_ready", 32'(input_tready), 0);
        chk("early_drop_tvalid", 32'(output_tvalid), 0);

        // Round robin: all ports valid, bursts of 4 with one bubble each.
        for (int p = 0; p < PORTS; p++) begin
            set_port(p, 16'hC000 | 16'(p), 16'hD000 | 16'(p));
        end
        input_tvalid = 4'b1111;
        for (int k = 1; k <= 25; k++) begin
            go();
            look();
            if (k % 5 == 1) begin
                chk("rr_bubble", 32'(output_tvalid), 0);
            end else begin
                chk("rr_tvalid", 32'(output_tvalid), 1);
                chk("rr_tid", 32'(output_tid), 32'(((k - 1) / 5) % PORTS));
                chk("rr_i", 32'(output_i_tdata), 32'h0000C000 | 32'(((k - 1) / 5) % PORTS));
            end
        end
        go();
        look();
        chk("rr_grant1", 32'(input_tready), 32'h2);
        go();
        look();
        chk("rr_tid1", 32'(output_tid), 1);
        chk("rr_tvalid1", 32'(output_tvalid), 1);

        // Reset mid-burst of port 1.
        rst = 1'b1;
        go();
        rst = 1'b0;
        look();
        chk("mid_rst_tvalid", 32'(output_tvalid), 0);
        chk("mid_rst_i", 32'(output_i_tdata), 0);
        chk("mid_rst_q", 32'(output_q_tdata), 0);
        chk("mid_rst_tid", 32'(output_tid), 0);
        chk("mid_rst_ready", 32'(input_tready), 0);
        go();
        look();
        chk("post_rst_grant0", 32'(input_tready), 32'h1);
        go();
        look();
        chk("post_rst_tvalid", 32'(output_tvalid), 1);
        chk("post_rst_tid", 32'(output_tid), 0);
        chk("post_rst_i", 32'(output_i_tdata), 32'hC000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
